// File: rtl/lsu_pkg.sv
// Shared LSU types: store-size encoding and byte-enable masks.
// Also holds the lane-select helper used by the store merge path.
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_BYTE = 2'b00,
    ST_HALF = 2'b01,
    ST_WORD = 2'b10,
    ST_NONE = 2'b11
  } st_type_e;

  localparam logic [3:0] BE_NONE = 4'b0000;
  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_WORD = 4'b1111;

  // Halfword lanes ignore addr[0]; misalignment is flagged separately.
  function automatic logic [3:0] be_mask(
    input st_type_e   t,
    input logic [1:0] off
  );
    logic [3:0] m;
    m = BE_NONE;
    unique case (t)
      ST_BYTE: m = 4'(BE_BYTE << off);
      ST_HALF: m = off[1] ? BE_HALF_HI : BE_HALF_LO;
      ST_WORD: m = BE_WORD;
      ST_NONE: m = BE_NONE;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/store_data_rewrite_if.sv
// Bundle between the store-merge wrapper and its datapath.
// master drives the request, slave returns merged and registered data.
interface store_data_rewrite_if;
  import lsu_pkg::*;

  logic [1:0]  addr;
  st_type_e    st_type;
  logic [31:0] st_data;
  logic [31:0] ld_data;
  logic        vld;
  logic [31:0] new_data;
  logic [3:0]  be;
  logic        mis;
  logic [31:0] new_data_q;
  logic [3:0]  be_q;
  logic        vld_q;

  modport master (
    output addr, st_type, st_data, ld_data, vld,
    input  new_data, be, mis,
    input  new_data_q, be_q, vld_q
  );

  modport slave (
    input  addr, st_type, st_data, ld_data, vld,
    output new_data, be, mis,
    output new_data_q, be_q, vld_q
  );

endinterface

// File: rtl/lane_mux4.sv
// One byte lane of the merge: store byte when enabled, else load byte.
// Instantiated once per lane of the 32-bit word.
module lane_mux4 (
  input  logic       sel_i,
  input  logic [7:0] st_i,
  input  logic [7:0] ld_i,
  output logic [7:0] y_o
);

  assign y_o = sel_i ? st_i : ld_i;

endmodule

// File: rtl/store_data_rewrite_merge.sv
// Store merge datapath: lane replication, byte enables, misalign flag,
// plus the single valid-qualified output register.
module store_data_rewrite_merge
  import lsu_pkg::*;
(
  input logic             clk,
  input logic             rst,
  store_data_rewrite_if.slave bus
);

  logic [31:0] rep_d;
  logic [31:0] data_d;
  logic [3:0]  be_d;
  logic        mis_d;

  logic [31:0] data_q;
  logic [3:0]  be_q;
  logic        vld_q;

  // Replicate the operand so each lane already holds its store byte.
  always_comb begin
    rep_d = bus.st_data;
    case (bus.st_type)
      ST_BYTE: rep_d = {4{bus.st_data[7:0]}};
      ST_HALF: rep_d = {2{bus.st_data[15:0]}};
      default: rep_d = bus.st_data;
    endcase
  end

  assign be_d  = be_mask(bus.st_type, bus.addr);
  assign mis_d = (bus.st_type == ST_HALF) && bus.addr[0];

  for (genvar i = 0; i < 4; i++) begin : g_lane
    lane_mux4 u_lane (
      .sel_i (be_d[i]),
      .st_i  (rep_d[8*i +: 8]),
      .ld_i  (bus.ld_data[8*i +: 8]),
      .y_o   (data_d[8*i +: 8])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      be_q   <= '0;
      vld_q  <= 1'b0;
    end else begin
      vld_q <= bus.vld;
      if (bus.vld) begin
        data_q <= data_d;
        be_q   <= be_d;
      end
    end
  end

  assign bus.new_data   = data_d;
  assign bus.be         = be_d;
  assign bus.mis        = mis_d;
  assign bus.new_data_q = data_q;
  assign bus.be_q       = be_q;
  assign bus.vld_q      = vld_q;

endmodule

// File: rtl/store_data_rewrite.sv
// LSU store-data merge unit: combinational merge for memory write
// ports plus a one-cycle registered copy for pipelined ports.
module store_data_rewrite
  import lsu_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [1:0]  i_lsu_addr_segment,
  input  logic [1:0]  i_st_type,
  input  logic [31:0] i_st_data,
  input  logic [31:0] i_ld_data,
  input  logic        i_vld,
  output logic [31:0] o_st_new_data,
  output logic [3:0]  o_byte_en,
  output logic        o_misaligned,
  output logic [31:0] o_st_new_data_q,
  output logic [3:0]  o_byte_en_q,
  output logic        o_vld_q
);

  store_data_rewrite_if u_bus ();

  assign u_bus.addr    = i_lsu_addr_segment;
  assign u_bus.st_type = st_type_e'(i_st_type);
  assign u_bus.st_data = i_st_data;
  assign u_bus.ld_data = i_ld_data;
  assign u_bus.vld     = i_vld;

  store_data_rewrite_merge u_merge (
    .clk (i_clk),
    .rst (i_rst),
    .bus (u_bus.slave)
  );

  assign o_st_new_data   = u_bus.new_data;
  assign o_byte_en       = u_bus.be;
  assign o_misaligned    = u_bus.mis;
  assign o_st_new_data_q = u_bus.new_data_q;
  assign o_byte_en_q     = u_bus.be_q;
  assign o_vld_q         = u_bus.vld_q;

endmodule

// File: tb/tb_store_data_rewrite.sv
// Bench for store_data_rewrite: directed table, registered path,
// reset-vs-valid, and a random sweep against a byte-array model.
module tb_store_data_rewrite;
  import lsu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  store_data_rewrite_if bus ();

  store_data_rewrite dut (
    .i_clk              (clk),
    .i_rst              (rst),
    .i_lsu_addr_segment (bus.addr),
    .i_st_type          (bus.st_type),
    .i_st_data          (bus.st_data),
    .i_ld_data          (bus.ld_data),
    .i_vld              (bus.vld),
    .o_st_new_data      (bus.new_data),
    .o_byte_en          (bus.be),
    .o_misaligned       (bus.mis),
    .o_st_new_data_q    (bus.new_data_q),
    .o_byte_en_q        (bus.be_q),
    .o_vld_q            (bus.vld_q)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Golden model: plain byte array, lanes overwritten by store size.
  task automatic model(input int t, input int off,
                       input logic [31:0] st, input logic [31:0] ld,
                       output logic [31:0] d, output logic [3:0] be,
                       output logic mis);
    logic [7:0] b [4];
    int base;
    for (int i = 0; i < 4; i++) b[i] = ld[8*i +: 8];
    be  = 4'b0000;
    mis = 1'b0;
    if (t == 0) begin
      b[off] = st[7:0];
      be[off] = 1'b1;
    end else if (t == 1) begin
      base = (off / 2) * 2;
      b[base]   = st[7:0];
      b[base+1] = st[15:8];
      be[base]   = 1'b1;
      be[base+1] = 1'b1;
      mis = (off % 2) == 1;
    end else if (t == 2) begin
      for (int i = 0; i < 4; i++) b[i] = st[8*i +: 8];
      be = 4'b1111;
    end
    d = {b[3], b[2], b[1], b[0]};
  endtask

  task automatic drive(input int t, input int off, input logic [31:0] st,
                       input logic [31:0] ld, input logic v);
    bus.st_type = st_type_e'(t[1:0]);
    bus.addr    = off[1:0];
    bus.st_data = st;
    bus.ld_data = ld;
    bus.vld     = v;
  endtask

  logic [31:0] exp_d  [16];
  logic [3:0]  exp_be [16];
  logic        exp_mis[16];

  initial begin
    logic [31:0] md, st, ld, q_d;
    logic [3:0]  mbe, q_be;
    logic        mmis, q_v, v;
    int          t, off;

    exp_d = '{32'h112233DD, 32'h1122DD44, 32'h11DD3344, 32'hDD223344,
              32'h1122CCDD, 32'h1122CCDD, 32'hCCDD3344, 32'hCCDD3344,
              32'hAABBCCDD, 32'hAABBCCDD, 32'hAABBCCDD, 32'hAABBCCDD,
              32'h11223344, 32'h11223344, 32'h11223344, 32'h11223344};
    exp_be = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'h3, 4'hC, 4'hC,
               4'hF, 4'hF, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0};
    exp_mis = '{0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};

    rst = 1'b1;
    drive(3, 0, 32'h0, 32'h0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_data_q", bus.new_data_q, 32'h0);
    chk("rst_be_q", 32'(bus.be_q), 32'h0);
    chk("rst_vld_q", 32'(bus.vld_q), 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      drive(i / 4, i % 4, 32'hAABBCCDD, 32'h11223344, 1'b0);
      #1;
      chk($sformatf("dir_data_%0d", i), bus.new_data, exp_d[i]);
      chk($sformatf("dir_be_%0d", i), 32'(bus.be), 32'(exp_be[i]));
      chk($sformatf("dir_mis_%0d", i), 32'(bus.mis), 32'(exp_mis[i]));
    end

    @(negedge clk);
    drive(0, 2, 32'hAABBCCDD, 32'h11223344, 1'b1);
    @(negedge clk);
    chk("reg_vld_q", 32'(bus.vld_q), 32'h1);
    chk("reg_data_q", bus.new_data_q, 32'h11DD3344);
    chk("reg_be_q", 32'(bus.be_q), 32'h4);
    drive(2, 0, 32'h01020304, 32'h55667788, 1'b0);
    @(negedge clk);
    chk("hold_vld_q", 32'(bus.vld_q), 32'h0);
    chk("hold_data_q", bus.new_data_q, 32'h11DD3344);
    chk("hold_be_q", 32'(bus.be_q), 32'h4);

    rst = 1'b1;
    drive(2, 1, 32'hAABBCCDD, 32'h11223344, 1'b1);
    @(negedge clk);
    chk("rstv_data_q", bus.new_data_q, 32'h0);
    chk("rstv_be_q", 32'(bus.be_q), 32'h0);
    chk("rstv_vld_q", 32'(bus.vld_q), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("resume_vld_q", 32'(bus.vld_q), 32'h1);
    chk("resume_data_q", bus.new_data_q, 32'hAABBCCDD);
    chk("resume_be_q", 32'(bus.be_q), 32'hF);

    q_v  = 1'b1;
    q_d  = 32'hAABBCCDD;
    q_be = 4'hF;
    for (int i = 0; i < 200; i++) begin
      if (i < 16) begin
        t   = i % 4;
        off = i / 4;
      end else begin
        t   = int'($urandom_range(3, 0));
        off = int'($urandom_range(3, 0));
      end
      st = $urandom;
      ld = $urandom;
      v  = 1'($urandom_range(1, 0));
      drive(t, off, st, ld, v);
      #1;
      model(t, off, st, ld, md, mbe, mmis);
      chk($sformatf("rnd_data_%0d", i), bus.new_data, md);
      chk($sformatf("rnd_be_%0d", i), 32'(bus.be), 32'(mbe));
      chk($sformatf("rnd_mis_%0d", i), 32'(bus.mis), 32'(mmis));
      n_cmp++;
      assert (!$isunknown({bus.new_data, bus.be, bus.mis,
                           bus.new_data_q, bus.be_q, bus.vld_q})) else begin
        n_bad++;
        $error("FAIL rnd_xfree_%0d observed=X expected=known", i);
      end
      if (v) begin
        q_d  = md;
        q_be = mbe;
      end
      q_v = v;
      @(negedge clk);
      chk($sformatf("rnd_vld_q_%0d", i), 32'(bus.vld_q), 32'(q_v));
      chk($sformatf("rnd_data_q_%0d", i), bus.new_data_q, q_d);
      chk($sformatf("rnd_be_q_%0d", i), 32'(bus.be_q), 32'(q_be));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
